// File: rtl/wta_chunk_sequencer_if.sv
// Chunk-stream, tree-port and result-handshake bundle for wta_chunk_sequencer.
// Optional out_pixcnt signal is present only when WTA_PIXCNT_EN is defined.
interface wta_chunk_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CHUNK  = 16,
    parameter int unsigned IDX_W  = 10
);
    localparam int unsigned BUS_W = DATA_W * CHUNK;

    logic              in_valid;
    logic              in_ready;
    logic [BUS_W-1:0]  in_data;
    logic              tree_en;
    logic [BUS_W-1:0]  tree_din;
    logic [DATA_W-1:0] tree_max;
    logic [IDX_W-1:0]  tree_idx;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
`ifdef WTA_PIXCNT_EN
    logic [15:0]       out_pixcnt;

    modport master (
        output in_valid, in_data, tree_max, tree_idx, out_ready,
        input  in_ready, tree_en, tree_din, out_valid, out_max, out_idx, busy, out_pixcnt
    );
    modport slave (
        input  in_valid, in_data, tree_max, tree_idx, out_ready,
        output in_ready, tree_en, tree_din, out_valid, out_max, out_idx, busy, out_pixcnt
    );
`else
    modport master (
        output in_valid, in_data, tree_max, tree_idx, out_ready,
        input  in_ready, tree_en, tree_din, out_valid, out_max, out_idx, busy
    );
    modport slave (
        input  in_valid, in_data, tree_max, tree_idx, out_ready,
        output in_ready, tree_en, tree_din, out_valid, out_max, out_idx, busy
    );
`endif
endinterface

// File: rtl/wta_chunk_sequencer.sv
// Winner-take-all sequencer: streams cost chunks through an external max tree and
// folds per-chunk winners into one result per pixel. WTA_PIXCNT_EN adds out_pixcnt.
module wta_chunk_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHUNK    = 16,
    parameter int unsigned NCHUNK   = 4,
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned TREE_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wta_chunk_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] CHUNK_IDX  = IDX_W'(CHUNK);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    logic              stall_c;
    logic              accept_c;
    logic              last_c;
    logic              fold_c;
    logic              take_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] fold_max_c;
    logic [IDX_W-1:0]  fold_idx_c;
    logic [IDX_W-1:0]  gidx_c;
    logic              tag_vld_c;
    logic              tag_last_c;
    logic              tag_busy_c;
    logic [CNT_W-1:0]  tag_cidx_c;

    // A held result freezes both the input side and the tree pipeline.
    assign stall_c     = out_valid_q && !bus.out_ready;
    assign bus.tree_en  = !stall_c;
    assign bus.in_ready = !stall_c;
    assign bus.tree_din = bus.in_data;
    assign accept_c    = bus.in_valid && !stall_c;
    assign last_c      = (cnt_q == LAST_CHUNK);

    // Tag pipeline mirrors the tree latency so each tree result knows its chunk.
    if (TREE_LAT == 0) begin : g_tag_comb
        assign tag_vld_c  = accept_c;
        assign tag_cidx_c = cnt_q;
        assign tag_last_c = last_c;
        assign tag_busy_c = 1'b0;
    end else begin : g_tag_pipe
        logic [TREE_LAT-1:0] vld_q;
        logic [TREE_LAT-1:0] last_q;
        logic [CNT_W-1:0]    cidx_q [TREE_LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= '0;
                last_q <= '0;
                cidx_q <= '{default: '0};
            end else if (!stall_c) begin
                vld_q[0]  <= accept_c;
                last_q[0] <= last_c;
                cidx_q[0] <= cnt_q;
                for (int i = 1; i < TREE_LAT; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    last_q[i] <= last_q[i-1];
                    cidx_q[i] <= cidx_q[i-1];
                end
            end
        end

        assign tag_vld_c  = vld_q[TREE_LAT-1];
        assign tag_cidx_c = cidx_q[TREE_LAT-1];
        assign tag_last_c = last_q[TREE_LAT-1];
        assign tag_busy_c = |vld_q;
    end

    // Candidate winner after folding the chunk currently leaving the tree.
    always_comb begin
        gidx_c     = IDX_W'(tag_cidx_c) * CHUNK_IDX + bus.tree_idx;
        take_c     = (tag_cidx_c == '0) || (bus.tree_max > best_q);
        fold_max_c = take_c ? bus.tree_max : best_q;
        fold_idx_c = take_c ? gidx_c : best_idx_q;
        fold_c     = tag_vld_c && !stall_c;
    end

    always_comb begin
        cnt_d       = cnt_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;
        out_valid_d = stall_c;
        if (accept_c) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
        if (fold_c) begin
            best_d     = fold_max_c;
            best_idx_d = fold_idx_c;
            if (tag_last_c) begin
                out_max_d   = fold_max_c;
                out_idx_d   = fold_idx_c;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.busy      = (cnt_q != '0) || tag_busy_c;

`ifdef WTA_PIXCNT_EN
    logic [15:0] pixcnt_q, pixcnt_d;

    always_comb begin
        pixcnt_d = pixcnt_q;
        if (out_valid_q && bus.out_ready) begin
            pixcnt_d = pixcnt_q + 16'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixcnt_q <= '0;
        end else begin
            pixcnt_q <= pixcnt_d;
        end
    end

    assign bus.out_pixcnt = pixcnt_q;
`endif

endmodule
